imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a program image as a byte stream
//  (e.g. from a UART receiver) and writes it as 32-bit words into instruction memory.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 30 +++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and memory geometry.
// No logic; no latency; no backpressure.
package imem_loader_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LEN   = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] CSUM  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;
   localparam logic [2:0] ERR   = 3'd6;

   localparam int IMEM_DEPTH_WORDS = 2048;
   localparam int WORD_BYTES       = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes into a little-endian 32-bit word; word/word_valid are valid in the 4th-byte cycle.
// Latency: combinational word on the 4th byte. Backpressure: none, the caller gates byte_en with its handshake.
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt;
   logic [31:0] shreg;

   // New byte enters at the top so the first byte ends up in bits [7:0].
   assign word       = {byte_in, shreg[31:8]};
   assign word_valid = byte_en && (cnt == 2'd3);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt   <= 2'd0;
         shreg <= 32'd0;
      end else if (byte_en) begin
         cnt   <= cnt + 2'd1;
         shreg <= word;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit words, holding the core meanwhile.
// Latency: mem_we one cycle after each 4th data byte. Backpressure: in_ready drops during WRITE/IDLE/DONE/ERR.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          DEPTH     = IMEM_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [15:0] words_left
);

`ifdef IMEM_LOADER_CSUM_EN
   localparam logic [2:0] AFTER_LAST = CSUM;
   logic [7:0] csum;
`else
   localparam logic [2:0] AFTER_LAST = DONE;
`endif

   logic [2:0]  state;
   logic        start_ok;
   logic        in_hs;
   logic        pack_en;
   logic [31:0] word;
   logic        word_valid;

   assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
   assign in_hs    = in_valid && in_ready;
   assign pack_en  = in_hs && (state == LEN || state == DATA);

   always_comb begin
      in_ready = (state == LEN) || (state == DATA);
`ifdef IMEM_LOADER_CSUM_EN
      in_ready = in_ready || (state == CSUM);
`endif
      mem_we   = (state == WRITE);
      cpu_hold = (state == LEN) || (state == DATA) || (state == WRITE) || (state == CSUM);
      done     = (state == DONE);
      error    = (state == ERR);
   end

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_ok),
      .byte_en    (pack_en),
      .byte_in    (in_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= 32'd0;
         words_left <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
         csum       <= 8'd0;
`endif
      end else if (start_ok) begin
         state      <= LEN;
         mem_addr   <= BASE_ADDR;
         words_left <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         case (state)
            LEN: begin
               // The N check up front is what keeps mem_addr inside the memory.
               if (word_valid) begin
                  if (word == 32'd0) begin
                     state <= AFTER_LAST;
                  end else if (word > 32'(DEPTH)) begin
                     state <= ERR;
                  end else begin
                     state      <= DATA;
                     words_left <= word[15:0];
                  end
               end
            end
            DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
               if (in_hs) csum <= csum + in_data;
`endif
               if (word_valid) begin
                  mem_wdata <= word;
                  state     <= WRITE;
               end
            end
            WRITE: begin
               mem_addr   <= mem_addr + 32'd4;
               words_left <= words_left - 16'd1;
               state      <= (words_left == 16'd1) ? AFTER_LAST : DATA;
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
               if (in_hs) state <= (in_data == csum) ? DONE : ERR;
            end
`endif
            DONE:    state <= IDLE;
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor pops and compares on mem_we.
module tb_imem_loader;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_we, cpu_hold, done, error;
   logic [31:0] mem_addr, mem_wdata;
   logic [15:0] words_left;

   int   n_cmp = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   wr_t  exp_q[$];
   logic [31:0] words_q[$];

   imem_loader #(.DEPTH(2048), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error), .words_left(words_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_wr: addr 0x%08h data 0x%08h with no write expected", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic hs;
      in_valid = 1'b0;
      if (gap > 0) tick(gap);
      in_valid = 1'b1;
      in_data  = b;
      hs = 1'b0;
      for (int t = 0; t < 50 && !hs; t++) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!hs) begin
         n_cmp++;
         n_err++;
         $display("FAIL handshake_timeout: byte 0x%02h got no in_ready within 50 cycles", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int k = 0; k < 4; k++)
         send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   // Full load of words_q; bad_csum adds an offset to the trailing checksum byte.
   task automatic run_load(input int maxgap, input logic [7:0] bad_csum);
      logic [7:0] sum;
      wr_t e;
      sum = 8'h00;
      start_pulse();
      check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
      send_word(words_q.size(), maxgap);
      check("words_left_init", {16'd0, words_left}, words_q.size());
      for (int i = 0; i < words_q.size(); i++) begin
         e.addr = BASE + 32'(4 * i);
         e.data = words_q[i];
         exp_q.push_back(e);
         for (int k = 0; k < 4; k++) sum = sum + words_q[i][8*k +: 8];
         send_word(words_q[i], maxgap);
      end
`ifdef IMEM_LOADER_CSUM_EN
      send_byte(sum + bad_csum, 0);
`else
      if (bad_csum != 8'h00) sum = 8'h00;
`endif
      tick(4);
   endtask

   task automatic expect_end(input string tag, input int done_before, input bit ok);
      check({tag, "_done_cnt"}, done_cnt - done_before, ok ? 1 : 0);
      check({tag, "_error"}, {31'd0, error}, ok ? 32'd0 : 32'd1);
      check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_exp_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int d0;
      tick(3);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, BASE);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_hold", {31'd0, cpu_hold}, 32'd0);
      check("rst_done_error", {30'd0, done, error}, 32'd0);
      check("rst_words_left", {16'd0, words_left}, 32'd0);
      rst = 1'b0;
      tick(2);

      // 1: two-word program
      d0 = done_cnt;
      words_q = '{32'h0000_0513, 32'h0010_0593};
      run_load(0, 8'h00);
      expect_end("t1", d0, 1'b1);
      check("t1_words_left", {16'd0, words_left}, 32'd0);
      check("t1_next_addr", mem_addr, BASE + 32'd8);

      // 2: empty image
      d0 = done_cnt;
      words_q.delete();
      run_load(0, 8'h00);
      expect_end("t2", d0, 1'b1);

      // 3: length one past capacity (2049 = 01 08 00 00)
      d0 = done_cnt;
      start_pulse();
      send_word(32'd2049, 0);
      tick(3);
      expect_end("t3", d0, 1'b0);
      check("t3_in_ready", {31'd0, in_ready}, 32'd0);
      start_pulse();
      check("t3_error_cleared", {31'd0, error}, 32'd0);
      check("t3_hold_again", {31'd0, cpu_hold}, 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);

      // 4: sixteen words with random input gaps
      d0 = done_cnt;
      words_q.delete();
      for (int i = 0; i < 16; i++)
         words_q.push_back({8'(4*i*7 + 22), 8'(4*i*7 + 15), 8'(4*i*7 + 8), 8'(4*i*7 + 1)});
      run_load(7, 8'h00);
      expect_end("t4", d0, 1'b1);
      check("t4_next_addr", mem_addr, BASE + 32'd64);

      // 5: reset after six data bytes of a four-word image
      start_pulse();
      send_word(32'd4, 0);
      exp_q.push_back('{addr: BASE, data: 32'h0000_0237});
      send_word(32'h0000_0237, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst = 1'b1;
      tick(1);
      check("t5_mem_we", {31'd0, mem_we}, 32'd0);
      check("t5_in_ready", {31'd0, in_ready}, 32'd0);
      check("t5_mem_addr", mem_addr, BASE);
      check("t5_mem_wdata", mem_wdata, 32'd0);
      check("t5_hold", {31'd0, cpu_hold}, 32'd0);
      check("t5_words_left", {16'd0, words_left}, 32'd0);
      rst = 1'b0;
      tick(5);
      check("t5_exp_empty", exp_q.size(), 0);
      d0 = done_cnt;
      words_q = '{32'h0000_0513, 32'h0010_0593};
      run_load(0, 8'h00);
      expect_end("t5_reload", d0, 1'b1);

`ifdef IMEM_LOADER_CSUM_EN
      // 6: checksum good, then off by one (write is still kept)
      d0 = done_cnt;
      words_q = '{32'hDEAD_BEEF};
      run_load(0, 8'h00);
      expect_end("t6_good", d0, 1'b1);
      d0 = done_cnt;
      run_load(0, 8'h01);
      expect_end("t6_bad", d0, 1'b0);
`endif

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
